// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the clk_div_ctrl clock-enable divider.
// The package is the same whether or not CLK_DIV_CTRL_DUTY_EN is defined.
package clk_div_ctrl_pkg;

  localparam int unsigned DefaultCntW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StPend = 2'b10
  } state_e;

  // Number of high cycles of the duty-cycle level for ratio n.
  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter and active-ratio register for clk_div_ctrl.
// CLK_DIV_CTRL_DUTY_EN adds a registered ~50% duty level derived from the counter.
module clk_div_counter
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = DefaultCntW,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
`ifdef CLK_DIV_CTRL_DUTY_EN
  input  logic             run_next,
  output logic             div_clk,
`endif
  output logic             terminal,
  output logic [CNT_W-1:0] active_div
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;

  always_comb begin
    terminal = (cnt_q == div_q - CNT_W'(1));
    div_d    = load ? load_value : div_q;
    // A stopped counter sits at 0 so a restart always begins a full period.
    cnt_d    = (run && !terminal) ? cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= CNT_W'(DEFAULT_DIV);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign active_div = div_q;

`ifdef CLK_DIV_CTRL_DUTY_EN
  logic div_clk_q;

  // Registered from next-state values so the level tracks cnt without glitching.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_clk_q <= 1'b0;
    end else begin
      div_clk_q <= run_next && (32'(cnt_d) < half_ceil(32'(div_d)));
    end
  end

  assign div_clk = div_clk_q;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider: one ce_out pulse every N clk cycles, N loaded by valid/ready.
// Optional duty-cycle output div_clk_o is enabled with CLK_DIV_CTRL_DUTY_EN.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = DefaultCntW,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_ready,
  output logic             ce_out,
  output logic [CNT_W-1:0] active_div,
  output logic             busy,
  output logic             div_err
`ifdef CLK_DIV_CTRL_DUTY_EN
  ,
  output logic             div_clk_o
`endif
);

  state_e           state_q;
  logic [CNT_W-1:0] pend_q;
  logic             err_q;

  logic             hs;
  logic             hs_ok;
  logic             run;
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             terminal;

  always_comb begin
    div_ready  = (state_q != StPend);
    busy       = (state_q == StPend);
    hs         = div_valid && div_ready;
    hs_ok      = hs && (div_value != '0);
    run        = (state_q != StIdle) && enable;
    load       = 1'b0;
    load_value = div_value;
    unique case (state_q)
      StIdle: load = hs_ok;
      // A ratio accepted in the same cycle the block stops goes straight into force.
      StRun:  load = hs_ok && !enable;
      StPend: begin
        load       = !enable || terminal;
        load_value = pend_q;
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= hs && (div_value == '0);
      unique case (state_q)
        StIdle: begin
          if (enable) state_q <= StRun;
        end
        StRun: begin
          if (!enable) begin
            state_q <= StIdle;
          end else if (hs_ok) begin
            pend_q  <= div_value;
            state_q <= StPend;
          end
        end
        StPend: begin
          if (!enable) begin
            state_q <= StIdle;
          end else if (terminal) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  clk_div_counter #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .load       (load),
    .load_value (load_value),
`ifdef CLK_DIV_CTRL_DUTY_EN
    .run_next   (enable),
    .div_clk    (div_clk_o),
`endif
    .terminal   (terminal),
    .active_div (active_div)
  );

  assign ce_out  = (state_q != StIdle) && terminal;
  assign div_err = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: per-cycle period model plus directed literal checks.
// Define CLK_DIV_CTRL_DUTY_EN to also check div_clk_o.
module tb_clk_div_ctrl;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned DEFAULT_DIV = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             div_valid;
  logic [CNT_W-1:0] div_value;
  logic             div_ready;
  logic             ce_out;
  logic [CNT_W-1:0] active_div;
  logic             busy;
  logic             div_err;
`ifdef CLK_DIV_CTRL_DUTY_EN
  logic             div_clk_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .div_valid  (div_valid),
    .div_value  (div_value),
    .div_ready  (div_ready),
    .ce_out     (ce_out),
    .active_div (active_div),
    .busy       (busy),
`ifdef CLK_DIV_CTRL_DUTY_EN
    .div_clk_o  (div_clk_o),
`endif
    .div_err    (div_err)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: whether a period is running, its ratio, how far into it we are, any queued ratio.
  bit m_on       = 1'b0;
  int m_n        = DEFAULT_DIV;
  int m_elapsed  = 0;
  bit m_has_pend = 1'b0;
  int m_pend     = 0;
  bit m_err      = 1'b0;

  always begin
    @(posedge clk);
    begin
      bit take;
      bit old_has_pend;
      int old_pend;
      bit period_done;
      old_has_pend = m_has_pend;
      old_pend     = m_pend;
      period_done  = m_on && (m_elapsed == m_n - 1);
      if (reset) begin
        m_on = 0; m_n = DEFAULT_DIV; m_elapsed = 0; m_has_pend = 0; m_pend = 0; m_err = 0;
      end else begin
        take  = div_valid && !m_has_pend;
        m_err = take && (div_value == 0);
        if (take && div_value != 0) begin
          if (m_on) begin
            m_has_pend = 1; m_pend = int'(div_value);
          end else begin
            m_n = int'(div_value);
          end
        end
        if (!enable) begin
          if (m_has_pend) m_n = m_pend;
          m_has_pend = 0; m_on = 0; m_elapsed = 0;
        end else if (!m_on) begin
          m_on = 1; m_elapsed = 0;
        end else if (period_done) begin
          m_elapsed = 0;
          // Only a ratio queued before this boundary takes effect at it.
          if (old_has_pend) begin
            m_n = old_pend; m_has_pend = 0;
          end
        end else begin
          m_elapsed++;
        end
      end
    end
    @(negedge clk);
    check("ce_out", int'(ce_out), int'(m_on && m_elapsed == m_n - 1));
    check("active_div", int'(active_div), m_n);
    check("busy", int'(busy), int'(m_has_pend));
    check("div_ready", int'(div_ready), int'(!m_has_pend));
    check("div_err", int'(div_err), int'(m_err));
`ifdef CLK_DIV_CTRL_DUTY_EN
    check("div_clk_o", int'(div_clk_o), int'(m_on && m_elapsed < (m_n + 1) / 2));
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_idle(input int n);
    enable = 0;
    tick(1);
    div_valid = 1; div_value = CNT_W'(n);
    tick(1);
    div_valid = 0;
  endtask

  initial begin
    reset = 1; enable = 0; div_valid = 0; div_value = '0;
    tick(2);
    reset = 0;
    check("rst active_div", int'(active_div), 2);
    check("rst div_ready", int'(div_ready), 1);
    check("rst busy", int'(busy), 0);
    check("rst ce_out", int'(ce_out), 0);
    check("rst div_err", int'(div_err), 0);

    // Default ratio 2: pulses on cycles 1,3 after RUN entry.
    enable = 1;
    tick(1); check("n2 c0", int'(ce_out), 0);
    tick(1); check("n2 c1", int'(ce_out), 1);
    tick(1); check("n2 c2", int'(ce_out), 0);
    tick(1); check("n2 c3", int'(ce_out), 1);

    // N=4, request 3 at cnt=1: periods 4 then 3.
    load_idle(4);
    check("idle load 4", int'(active_div), 4);
    enable = 1;
    tick(2);
    div_valid = 1; div_value = 8'd3;
    tick(1); div_valid = 0;
    check("pend busy", int'(busy), 1);
    check("pend ready", int'(div_ready), 0);
    check("pend c2 ce", int'(ce_out), 0);
    tick(1); check("pend old term ce", int'(ce_out), 1);
    check("pend old term busy", int'(busy), 1);
    tick(1); check("switch active", int'(active_div), 3);
    check("switch busy", int'(busy), 0);
    check("switch ce", int'(ce_out), 0);
    tick(2); check("new period ce", int'(ce_out), 1);

    // Load 5 while idle: first pulse 4 cycles after RUN entry, then every 5.
    load_idle(5);
    check("idle5 busy", int'(busy), 0);
    check("idle5 active", int'(active_div), 5);
    enable = 1;
    tick(1);
    tick(3); check("n5 c3", int'(ce_out), 0);
    tick(1); check("n5 c4", int'(ce_out), 1);
    tick(4); check("n5 c8", int'(ce_out), 0);
    tick(1); check("n5 c9", int'(ce_out), 1);

    // Zero ratio while running: error pulse, nothing else changes.
    div_valid = 1; div_value = 8'd0;
    tick(1); div_valid = 0;
    check("zero err", int'(div_err), 1);
    check("zero active", int'(active_div), 5);
    check("zero busy", int'(busy), 0);
    tick(1); check("zero err clears", int'(div_err), 0);
    tick(3); check("zero period kept", int'(ce_out), 1);

    // PEND 8->2, enable drops at cnt=3: ratio applied on entering IDLE.
    load_idle(8);
    enable = 1;
    tick(1);
    div_valid = 1; div_value = 8'd2;
    tick(1); div_valid = 0;
    tick(2); check("pend8 busy", int'(busy), 1);
    enable = 0;
    tick(1);
    check("drop ce", int'(ce_out), 0);
    check("drop active", int'(active_div), 2);
    check("drop busy", int'(busy), 0);
    enable = 1;
    tick(1); check("re-en c0", int'(ce_out), 0);
    tick(1); check("re-en c1", int'(ce_out), 1);
    tick(1); check("re-en c2", int'(ce_out), 0);
    tick(1); check("re-en c3", int'(ce_out), 1);

    // Enable drop exactly on the PEND terminal cycle.
    load_idle(3);
    enable = 1;
    tick(1);
    div_valid = 1; div_value = 8'd4;
    tick(1); div_valid = 0;
    tick(1); check("term drop ce", int'(ce_out), 1);
    enable = 0;
    tick(1);
    check("term drop active", int'(active_div), 4);
    check("term drop busy", int'(busy), 0);

    // Reset while pending with N=6.
    load_idle(6);
    enable = 1;
    tick(1);
    div_valid = 1; div_value = 8'd3;
    tick(1); div_valid = 0;
    check("pre-rst busy", int'(busy), 1);
    reset = 1;
    tick(1);
    check("mid-rst active", int'(active_div), 2);
    check("mid-rst busy", int'(busy), 0);
    check("mid-rst ready", int'(div_ready), 1);
    check("mid-rst ce", int'(ce_out), 0);
    reset = 0;

    // N=1: continuous enable.
    load_idle(1);
    enable = 1;
    tick(1); check("n1 c0", int'(ce_out), 1);
    tick(1); check("n1 c1", int'(ce_out), 1);
    tick(1); check("n1 c2", int'(ce_out), 1);

`ifdef CLK_DIV_CTRL_DUTY_EN
    begin
      logic [9:0] duty_pat;
      duty_pat = 10'b1110011100;
      load_idle(5);
      check("duty idle", int'(div_clk_o), 0);
      enable = 1;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        check("duty n5", int'(div_clk_o), int'(duty_pat[9 - i]));
      end
      enable = 0;
      tick(1); check("duty off", int'(div_clk_o), 0);
    end
`endif

    enable = 0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
